fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Single-clock, fully parametrised FIFO; next generation of the team's FIFO (fifo_top) for same-clock paths.
//  Adds configurable width/depth and a standard or first-word-fall-through read mode.
//  Adds almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow errors and sync flush.
//  Sits between a producer and a consumer in the same clock domain; no CDC logic inside.
// PARAMETERS
//  DATA_W     8   data word width in bits (>=1)
//  DEPTH      16  number of entries; power of two, >=2; ADDR_W = $clog2(DEPTH)
//  AF_THRESH  14  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  2   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//  FWFT       0   0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through
// PORTS
//  clk           in   1         single clock, rising edge
//  rst           in   1         asynchronous reset, active-low
//  flush         in   1         sync clear of contents (pointers/count), active-high
//  push          in   1         write request
//  wr_data       in   DATA_W    write data, sampled on accepted push
//  pop           in   1         read request
//  rd_data       out  DATA_W    read data
//  rd_valid      out  1         rd_data holds a valid word
//  full          out  1         count == DEPTH
//  empty         out  1         count == 0
//  almost_full   out  1         count >= AF_THRESH
//  almost_empty  out  1         count <= AE_THRESH
//  count         out  ADDR_W+1  current occupancy, 0..DEPTH
//  overflow      out  1         sticky: push rejected since last err_clr
//  underflow     out  1         sticky: pop rejected since last err_clr
//  err_clr       in   1         sync clear of overflow/underflow
// BEHAVIOUR
//  Reset (rst=0, async):
//   - pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
//   - empty=1, almost_empty=1, full=0, almost_full=0.
//   - Memory contents are not reset.
//  Pointers:
//   - wr_ptr/rd_ptr are ADDR_W+1 bits (MSB = wrap bit); count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
//   - All flags decode from the registered pointers, so they change only on clk edges.
//  Accept rules, evaluated per cycle on pre-edge state:
//   - pop_ok  = pop & ~empty.
//   - push_ok = push & (~full | pop_ok): push on full is accepted if a pop is accepted that same cycle.
//   - push & ~push_ok sets overflow; pop & ~pop_ok sets underflow.
//   - Rejected ops leave pointers and memory unchanged.
//   - Push+pop on empty: push accepted, pop rejected, underflow=1, count becomes 1.
//   - Push+pop on full: both accepted, count stays DEPTH, no overflow.
//  Count update: +1 on push only, -1 on pop only, unchanged if both or neither.
//  FWFT=0 (standard read):
//   - Accepted pop registers mem[rd_ptr] into rd_data; rd_valid=1 the following cycle only.
//   - rd_data holds its value until the next accepted pop.
//  FWFT=1 (first-word-fall-through):
//   - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
//   - A word pushed into an empty FIFO appears on rd_data the cycle after the push edge.
//   - An accepted pop advances to the next word.
//  flush=1:
//   - Next edge: wr_ptr=rd_ptr=0, count=0, rd_valid=0.
//   - Flush wins over push/pop in the same cycle; dropped ops do not set the error flags.
//   - Flush does not clear overflow/underflow.
//  err_clr: clears both sticky flags next edge. A set in the same cycle wins over the clear.
//  Wrap-around: pointer LSBs wrap at DEPTH; full/empty stay correct across any number of wraps.
// TESTING  (DATA_W=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2 unless noted)
//  1. Push 5 words, drop rst mid-cycle -> count=0, empty=1, rd_valid=0, rd_data=0 immediately (async).
//  2. Push 0x00..0x0F -> almost_full=1 after 14th push, full=1 at count=16; 17th push -> overflow=1, count=16.
//  3. FWFT=0: from full, 16 pops -> rd_data 0x00..0x0F, each 1 cycle after its pop, rd_valid pulses.
//     Extra pop -> underflow=1, count=0.
//  4. Full + push 0x55 & pop same cycle -> count=16, no overflow, 0x55 read last.
//     Empty + push & pop -> underflow=1, count=1.
//  5. Push 10/pop 10, then push 16 (0x20..0x2F) -> full=1 with wrapped pointers; drain returns 0x20..0x2F in order.
//  6. FWFT=1: push 0xA5 into empty -> next cycle rd_data=0xA5, rd_valid=1 without pop.
//     flush -> next cycle empty=1, rd_valid=0; err_clr clears sticky flags.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// almost-full/almost-empty thresholds, occupancy count, sticky error flags and sync flush.
module fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   occ;
    logic              push_ok;
    logic              pop_ok;

    // The extra MSB on each pointer is a wrap bit, so the difference is the
    // true occupancy 0..DEPTH and full/empty never alias.
    assign occ          = wr_ptr - rd_ptr;
    assign count        = occ;
    assign full         = (occ == DEPTH_C);
    assign empty        = (occ == '0);
    assign almost_full  = (occ >= AF_C);
    assign almost_empty = (occ <= AE_C);

    // Handshake: push/pop are requests; an op takes effect on the edge only when
    // accepted. A push on full is accepted if a pop is accepted the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    // Ops dropped by a flush are not errors; a new error beats err_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~err_clr) | (push & ~push_ok & ~flush);
            underflow <= (underflow & ~err_clr) | (pop  & ~pop_ok  & ~flush);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem[rd_ptr[ADDR_W-1:0]];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= pop_ok & ~flush;
                    if (pop_ok && !flush) rd_data_q <= mem[rd_ptr[ADDR_W-1:0]];
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: one standard-read and one FWFT instance share the
// stimulus; a queue model predicts flags and a scoreboard checks read data.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush, push, pop, err_clr;
    logic [7:0] wr_data;

    logic [7:0] s_rdd, f_rdd;
    logic       s_rdv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_rdv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_count, f_count;

    fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .wr_data(wr_data), .pop(pop),
        .rd_data(s_rdd), .rd_valid(s_rdv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr)
    );

    fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .wr_data(wr_data), .pop(pop),
        .rd_data(f_rdd), .rd_valid(f_rdv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model and scoreboard ----------------
    logic [7:0] mdl_q[$];
    logic [7:0] exp_q[$];
    logic       m_ovf, m_unf, m_rdv;
    int         n_tests = 0;
    int         n_fail  = 0;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] data;
        int         exp_count;
        logic       exp_af;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rdv = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic [7:0] d,
                              input logic f, input logic e);
        int  c;
        logic pok, wok;
        c = mdl_q.size();
        if (e) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (f) begin
            mdl_q.delete();
            m_rdv = 1'b0;
        end else begin
            pok = q && (c != 0);
            wok = p && ((c != 16) || pok);
            if (pok) exp_q.push_back(mdl_q.pop_front());
            if (wok) mdl_q.push_back(d);
            if (p && !wok) m_ovf = 1'b1;
            if (q && !pok) m_unf = 1'b1;
            m_rdv = pok;
        end
    endtask

    task automatic check_all();
        int c;
        c = mdl_q.size();
        chk("count", 32'(s_count), 32'(c));
        chk("full", 32'(s_full), 32'(c == 16));
        chk("empty", 32'(s_empty), 32'(c == 0));
        chk("almost_full", 32'(s_af), 32'(c >= 14));
        chk("almost_empty", 32'(s_ae), 32'(c <= 2));
        chk("overflow", 32'(s_ovf), 32'(m_ovf));
        chk("underflow", 32'(s_unf), 32'(m_unf));
        chk("rd_valid", 32'(s_rdv), 32'(m_rdv));
        if (m_rdv) begin
            if (exp_q.size() == 0) chk("scoreboard_depth", 32'(0), 32'(1));
            else                   chk("rd_data", 32'(s_rdd), 32'(exp_q.pop_front()));
        end
        chk("fw_count", 32'(f_count), 32'(c));
        chk("fw_full", 32'(f_full), 32'(c == 16));
        chk("fw_overflow", 32'(f_ovf), 32'(m_ovf));
        chk("fw_underflow", 32'(f_unf), 32'(m_unf));
        chk("fw_rd_valid", 32'(f_rdv), 32'(c != 0));
        if (c != 0) chk("fw_rd_data", 32'(f_rdd), 32'(mdl_q[0]));
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; inputs are held across the next rising edge.
    task automatic cyc(input logic p, input logic q, input logic [7:0] d,
                       input logic f = 1'b0, input logic e = 1'b0);
        push = p; pop = q; wr_data = d; flush = f; err_clr = e;
        @(posedge clk);
        model_step(p, q, d, f, e);
        #1;
        check_all();
        @(negedge clk);
        push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; wr_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_rd_data", 32'(s_rdd), 32'(0));
        rst = 1'b1;

        // 1: asynchronous reset in the middle of a cycle
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
        cyc(1'b0, 1'b1, 8'h00);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t1_rd_data", 32'(s_rdd), 32'(0));
        @(negedge clk);
        rst = 1'b1;

        // 2: fill past the top, table-driven
        for (int i = 0; i < 17; i++) begin
            vecs[i].push      = 1'b1;
            vecs[i].pop       = 1'b0;
            vecs[i].data      = 8'(i);
            vecs[i].exp_count = (i < 16) ? i + 1 : 16;
            vecs[i].exp_af    = (i >= 13);
            vecs[i].exp_full  = (i >= 15);
            vecs[i].exp_ovf   = (i == 16);
        end
        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].push, vecs[i].pop, vecs[i].data);
            chk("t2_count", 32'(s_count), 32'(vecs[i].exp_count));
            chk("t2_almost_full", 32'(s_af), 32'(vecs[i].exp_af));
            chk("t2_full", 32'(s_full), 32'(vecs[i].exp_full));
            chk("t2_overflow", 32'(s_ovf), 32'(vecs[i].exp_ovf));
        end

        // 3: drain in order, then pop on empty
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("t3_data", 32'(s_rdd), 32'(i));
            chk("t3_rd_valid", 32'(s_rdv), 32'(1));
        end
        cyc(1'b0, 1'b0, 8'h00);
        chk("t3_rd_valid_drop", 32'(s_rdv), 32'(0));
        chk("t3_rd_data_hold", 32'(s_rdd), 32'(8'h0F));
        cyc(1'b0, 1'b1, 8'h00);
        chk("t3_underflow", 32'(s_unf), 32'(1));
        chk("t3_count", 32'(s_count), 32'(0));
        chk("t3_rd_data_hold2", 32'(s_rdd), 32'(8'h0F));
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_err_clr", 32'({s_ovf, s_unf}), 32'(0));

        // 4: simultaneous push/pop on full and on empty
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
        cyc(1'b1, 1'b1, 8'h55);
        chk("t4_full_count", 32'(s_count), 32'(16));
        chk("t4_no_overflow", 32'(s_ovf), 32'(0));
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("t4_last", 32'(s_rdd), 32'(8'h55));
        cyc(1'b1, 1'b1, 8'h77);
        chk("t4_empty_underflow", 32'(s_unf), 32'(1));
        chk("t4_empty_count", 32'(s_count), 32'(1));
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

        // 5: wrap-around
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        chk("t5_full", 32'(s_full), 32'(1));
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("t5_data", 32'(s_rdd), 32'(8'h20 + i));
        end

        // 6: fall-through, flush and sticky-flag clearing
        cyc(1'b1, 1'b0, 8'hA5);
        chk("t6_fw_data", 32'(f_rdd), 32'(8'hA5));
        chk("t6_fw_valid", 32'(f_rdv), 32'(1));
        cyc(1'b1, 1'b0, 8'hB6);
        cyc(1'b1, 1'b1, 8'hC7, 1'b1);
        chk("t6_flush_empty", 32'(f_empty), 32'(1));
        chk("t6_flush_fw_valid", 32'(f_rdv), 32'(0));
        chk("t6_flush_no_err", 32'({s_ovf, s_unf}), 32'(0));
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t6_flush_keeps_unf", 32'(f_unf), 32'(1));
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        chk("t6_set_beats_clr", 32'(f_unf), 32'(1));
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t6_err_clr", 32'({f_ovf, f_unf}), 32'(0));

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
